segment7_scan: RTL
==================

// Module: segment7_scan
// PURPOSE
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
//   Sits directly upstream of segment7: drives its data/enable inputs one nibble at a
//   time and drives the active-low digit anodes. Features:
//   - Frame-synchronous value update, so there is no tearing.
//   - Per-slot blanking interval, against ghosting.
//   - Optional leading-zero suppression.
// PARAMETERS
//   REFRESH_DIV   50000  clock cycles per digit slot; must be >= 2
//   BLANK_CYCLES  1000   cycles at the start of each slot with the display dark; must be < REFRESH_DIV
// PORTS
//   clk          in   1   system clock, all state on rising edge
//   rst_n        in   1   asynchronous, active-low reset
//   value        in   16  hex value to display; [3:0] = rightmost digit 0
//   load         in   1   capture value into pending register this cycle
//   lz_blank     in   1   1 = suppress leading zeros (digits 3..1)
//   digit_data   out  4   nibble for segment7 .data
//   digit_en     out  1   segment7 .enable; 0 = segments dark
//   an           out  4   active-low anode selects; an[k] low = digit k lit
//   frame_done   out  1   1-cycle pulse at each frame boundary
// BEHAVIOUR
//   Reset (rst_n low, async):
//   - Internal state: div=0, idx=0, shadow=16'h0000, pending=16'h0000, pend=0.
//   - Outputs: digit_data=4'h0, digit_en=0, an=4'b1111, frame_done=0.
//   - Reset mid-slot aborts the scan immediately; the scan restarts at slot 0 with div=0.
//   Counters:
//   - div counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV), and wraps to 0.
//   - On each div wrap, idx increments modulo 4 (3 -> 0).
//   - Frame boundary = the edge where idx goes 3 -> 0.
//   Value path:
//   - load=1 sets pending<=value and pend<=1. A later load before the boundary overwrites pending.
//   - At a frame boundary, shadow<=value if load=1 that cycle; else shadow<=pending if pend=1;
//     else shadow is unchanged. pend clears at the boundary.
//   - frame_done=1 for exactly the cycle following the boundary edge (idx==0, div==0).
//   Output decode:
//   - Outputs are registered and change on the same edge as div/idx, with no extra latency.
//   - digit_data = shadow[4*idx+3 -: 4] at all times, including blanked cycles.
//   - lit = (div >= BLANK_CYCLES) && !suppressed(idx).
//   - suppressed(k) = lz_blank && k>=1 && shadow[15:4k]==0. Digit 0 is never suppressed,
//     so value 0 shows a single "0".
//   - digit_en = lit.
//   - an = lit ? ~(4'b0001 << idx) : 4'b1111.
//   - At most one an bit is ever low.
//   - lz_blank takes effect combinationally on the next slot decode; it is not frame-synchronised.
//   Slot timing:
//   - Each slot lasts exactly REFRESH_DIV cycles.
//   - Within a slot, a digit is dark for BLANK_CYCLES cycles and then lit for
//     REFRESH_DIV-BLANK_CYCLES cycles.
//   - A full frame lasts 4*REFRESH_DIV cycles.
// TESTING (bench uses REFRESH_DIV=8, BLANK_CYCLES=2; a segment7 instance is on the outputs)
//   1. Hold rst_n=0 and check outputs; release and wait 2 cycles.
//      -> During reset: an=1111, digit_en=0, frame_done=0.
//      -> After release: an=1111 on div=0,1; an=1110, digit_data=0 at div=2.
//   2. load value=16'h12AF for 1 cycle, lz_blank=0.
//      -> After the next frame_done, the lit slots show:
//         an=1110/F, 1101/A, 1011/2, 0111/1.
//      -> segment7 seg = 0001110, 0001000, 0100100, 1111001.
//   3. value=16'h0050 loaded, lz_blank=1.
//      -> Digits 3 and 2 stay dark: an=1111 for all 16 cycles of slots 2..3.
//      -> Digits 1 and 0 show 5 and 0.
//   4. value=16'h0000 loaded, lz_blank=1.
//      -> Only digit 0 is lit, showing 0; digits 3..1 stay dark.
//   5. load 16'h1111 mid-frame, then 16'h2222 mid-frame, then 16'h3333 on the boundary cycle.
//      -> shadow stays old until the boundary, then becomes 16'h3333.
//      -> No mixed digits are displayed within any frame.
//   6. Pulse rst_n low during slot 2, div=5.
//      -> an=1111 asynchronously, before the next clk edge.
//      -> After release, scan restarts at slot 0 and shadow=0.

Source files
------------

// File: rtl/segment7_scan.sv
// Four-digit time-multiplexed scan controller for a common-anode 7-segment display.
// The shown value is swapped only at frame boundaries, and each digit slot opens with a dark blanking interval.
module segment7_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  digit_data,
  output logic        digit_en,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);

  logic [DIV_W-1:0] div, div_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [15:0]      shadow, shadow_nxt;
  logic [15:0]      pending, pending_nxt;
  logic             pend, pend_nxt;
  logic             wrap, boundary, lit_nxt;
  logic [3:0]       an_nxt, data_nxt;

  function automatic logic suppressed(input logic [1:0] k, input logic [15:0] s,
                                      input logic lz);
    logic upper_zero;
    case (k)
      2'd1:    upper_zero = (s[15:4] == 12'h000);
      2'd2:    upper_zero = (s[15:8] == 8'h00);
      2'd3:    upper_zero = (s[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    return lz && upper_zero;
  endfunction

  function automatic logic [3:0] nibble(input logic [1:0] k, input logic [15:0] s);
    logic [3:0] n;
    case (k)
      2'd0:    n = s[3:0];
      2'd1:    n = s[7:4];
      2'd2:    n = s[11:8];
      default: n = s[15:12];
    endcase
    return n;
  endfunction

  // Outputs are decoded from the next counter/shadow state so they land on the same edge.
  always_comb begin
    wrap        = (div == DIV_LAST);
    div_nxt     = wrap ? '0 : div + 1'b1;
    idx_nxt     = wrap ? idx + 2'd1 : idx;
    boundary    = wrap && (idx == 2'd3);
    shadow_nxt  = shadow;
    pending_nxt = load ? value : pending;
    pend_nxt    = load | pend;
    if (boundary) begin
      if (load)      shadow_nxt = value;
      else if (pend) shadow_nxt = pending;
      pend_nxt = 1'b0;
    end
    lit_nxt  = (div_nxt >= BLANK_END) && !suppressed(idx_nxt, shadow_nxt, lz_blank);
    data_nxt = nibble(idx_nxt, shadow_nxt);
    an_nxt   = lit_nxt ? ~(4'b0001 << idx_nxt) : 4'b1111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      pending    <= 16'h0000;
      pend       <= 1'b0;
      digit_data <= 4'h0;
      digit_en   <= 1'b0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      div        <= div_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      pend       <= pend_nxt;
      digit_data <= data_nxt;
      digit_en   <= lit_nxt;
      an         <= an_nxt;
      frame_done <= boundary;
    end
  end

endmodule
